// File: rtl/fib_pkg.sv
// fib_pkg: default widths and the Fmax-index helper shared by the Fibonacci generator
package fib_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_INDEX_WIDTH = 8;
  function automatic int fib_max_index(input int width);
    logic [65:0] a, b, t;
    int n;
    a = '0;
    b = 66'd1;
    n = 0;
    while (b < (66'd1 << width)) begin
      t = a + b;
      a = b;
      b = t;
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/fib_step.sv
// fib_step: combinational next-term adder plus end-of-range flag
module fib_step
  import fib_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic [DATA_WIDTH:0]   nxt,
  output logic [DATA_WIDTH:0]   sum,
  output logic                  ovf
);
  assign sum = {1'b0, cur} + nxt;
  assign ovf = nxt[DATA_WIDTH];
endmodule

// File: rtl/fibonacci_generator.sv
// fibonacci_generator: free-running Fibonacci source; FIB_SATURATE_EN holds at Fmax instead of restarting
module fibonacci_generator
  import fib_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [DATA_WIDTH-1:0]  out,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   last
);
  if (DATA_WIDTH < 4 || DATA_WIDTH > 64) begin : g_bad_width
    $error("fibonacci_generator: DATA_WIDTH must be 4..64");
  end
  if (fib_max_index(DATA_WIDTH) > (2 ** INDEX_WIDTH) - 1) begin : g_index_too_narrow
    $error("fibonacci_generator: INDEX_WIDTH too small for DATA_WIDTH");
  end
  logic [DATA_WIDTH-1:0]  cur, cur_d;
  logic [DATA_WIDTH:0]    nxt, nxt_d, sum;
  logic [INDEX_WIDTH-1:0] index_d;
  logic                   end_range;
  fib_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .cur(cur),
    .nxt(nxt),
    .sum(sum),
    .ovf(end_range)
  );
  // next state: advance, or at Fmax either hold or reload F(0)/F(1)
  always_comb begin
`ifdef FIB_SATURATE_EN
    cur_d   = end_range ? cur : nxt[DATA_WIDTH-1:0];
    nxt_d   = end_range ? nxt : sum;
    index_d = end_range ? index : index + INDEX_WIDTH'(1);
`else
    cur_d   = end_range ? '0 : nxt[DATA_WIDTH-1:0];
    nxt_d   = end_range ? (DATA_WIDTH+1)'(1) : sum;
    index_d = end_range ? '0 : index + INDEX_WIDTH'(1);
`endif
  end
  // term registers with asynchronous clear to F(0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur   <= '0;
      nxt   <= (DATA_WIDTH+1)'(1);
      index <= '0;
    end else begin
      cur   <= cur_d;
      nxt   <= nxt_d;
      index <= index_d;
    end
  end
  assign out  = cur;
  assign last = end_range;
endmodule

// File: tb/tb_fibonacci_generator.sv
// tb_fibonacci_generator: directed checks of a 32-bit and an 8-bit generator sharing clock and reset
module tb_fibonacci_generator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] out32;
  logic [7:0]  idx32;
  logic        last32;
  logic [7:0]  out8;
  logic [3:0]  idx8;
  logic        last8;
  int checks = 0;
  int errors = 0;
  logic [31:0] seq [15] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
  logic [7:0]  f8 [14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

  fibonacci_generator #(.DATA_WIDTH(32), .INDEX_WIDTH(8)) u32 (
    .clk(clk), .reset(reset), .out(out32), .index(idx32), .last(last32)
  );
  fibonacci_generator #(.DATA_WIDTH(8), .INDEX_WIDTH(4)) u8 (
    .clk(clk), .reset(reset), .out(out8), .index(idx8), .last(last8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check8(input int k);
    int n;
`ifdef FIB_SATURATE_EN
    n = (k < 13) ? k : 13;
`else
    n = k % 14;
`endif
    check($sformatf("out8[%0d]", k), 64'(out8), 64'(f8[n]));
    check($sformatf("idx8[%0d]", k), 64'(idx8), 64'(n));
    check($sformatf("last8[%0d]", k), 64'(last8), 64'(n == 13));
  endtask

  initial begin
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_out32", 64'(out32), 64'd0);
      check("rst_idx32", 64'(idx32), 64'd0);
      check("rst_last32", 64'(last32), 64'd0);
      check("rst_out8", 64'(out8), 64'd0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk);
      #1;
      if (k <= 15) begin
        check($sformatf("out32[%0d]", k), 64'(out32), 64'(seq[k-1]));
        check($sformatf("idx32[%0d]", k), 64'(idx32), 64'(k));
        check($sformatf("last32[%0d]", k), 64'(last32), 64'd0);
      end
      if (k == 46) check("last32_46", 64'(last32), 64'd0);
      if (k == 47) begin
        check("fmax32", 64'(out32), 64'd2971215073);
        check("fmax32_idx", 64'(idx32), 64'd47);
        check("fmax32_last", 64'(last32), 64'd1);
      end
      if (k == 48) begin
        check("wrap32_out", 64'(out32), 64'd0);
        check("wrap32_idx", 64'(idx32), 64'd0);
        check("wrap32_last", 64'(last32), 64'd0);
      end
      if (k == 49) begin
        check("wrap32_out1", 64'(out32), 64'd1);
        check("wrap32_idx1", 64'(idx32), 64'd1);
      end
      check8(k);
    end
    repeat (9) @(posedge clk);
    #1;
    check("mid_out32", 64'(out32), 64'd55);
    #2;
    reset = 1'b1;
    #1;
    check("async_out32", 64'(out32), 64'd0);
    check("async_idx32", 64'(idx32), 64'd0);
    check("async_last32", 64'(last32), 64'd0);
    check("async_out8", 64'(out8), 64'd0);
    check("async_last8", 64'(last8), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("held_out32", 64'(out32), 64'd0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("restart_out32[%0d]", k), 64'(out32), 64'(seq[k-1]));
      check($sformatf("restart_out8[%0d]", k), 64'(out8), 64'(f8[k]));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
